// File: rtl/vga_scan_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scan_gen_if : scan position, sync and sprite-start bundle         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface vga_scan_gen_if;
  logic [9:0] spr_y;
  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       spr_start;

  modport master (
    input  spr_y,
    output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
           frame_start, spr_start
  );

  modport slave (
    output spr_y,
    input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
           frame_start, spr_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scan_gen : pixel-rate divider, raster counters, syncs and pulses  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vga_scan_gen #(
  parameter int CLK_DIV  = 4,
  parameter int RES_H    = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int RES_V    = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  vga_scan_gen_if.master scan_o
);

  localparam int H_TOTAL = RES_H + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = RES_V + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_RES    = 10'(RES_H);
  localparam logic [9:0] V_RES    = 10'(RES_V);
  localparam logic [9:0] H_SYNC_S = 10'(RES_H + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(RES_H + H_FP + H_SW - 1);
  localparam logic [9:0] V_SYNC_S = 10'(RES_V + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(RES_V + V_FP + V_SW - 1);

  logic       tick_w;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       spr_start_q, spr_start_d;
  logic       spr_done_q, spr_done_d;
  logic       h_wrap_w;
  logic       f_wrap_w;

  generate
    if (CLK_DIV == 1) begin : g_div_bypass
      assign tick_w = 1'b1;
    end else begin : g_div
      localparam int              DIV_W    = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_q, div_d;

      always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          div_q <= '0;
        end else begin
          div_q <= div_d;
        end
      end

      assign tick_w = (div_q == DIV_LAST);
    end
  endgenerate

  // Decodes are taken from the next counter values so they land on the same edge.
  always_comb begin
    h_wrap_w = tick_w && (h_q == H_LAST);
    f_wrap_w = h_wrap_w && (v_q == V_LAST);

    h_d = h_q;
    v_d = v_q;
    if (tick_w) begin
      h_d = h_wrap_w ? 10'd0 : h_q + 10'd1;
    end
    if (h_wrap_w) begin
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end

    hsync_d    = ((h_d >= H_SYNC_S) && (h_d <= H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((v_d >= V_SYNC_S) && (v_d <= V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (h_d < H_RES) && (v_d < V_RES);

    frame_start_d = f_wrap_w;

    // The done flag caps sprite starts at one per frame even if spr_y moves.
    spr_start_d = h_wrap_w && (v_d == scan_o.spr_y) && (scan_o.spr_y < V_RES)
                  && (!spr_done_q || f_wrap_w);
    spr_done_d  = f_wrap_w ? spr_start_d : (spr_done_q | spr_start_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
      spr_start_q   <= 1'b0;
      spr_done_q    <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      spr_start_q   <= spr_start_d;
      spr_done_q    <= spr_done_d;
    end
  end

  assign scan_o.pixel_tick  = tick_w;
  assign scan_o.pixel_x     = h_q;
  assign scan_o.pixel_y     = v_q;
  assign scan_o.hsync       = hsync_q;
  assign scan_o.vsync       = vsync_q;
  assign scan_o.video_on    = video_on_q;
  assign scan_o.frame_start = frame_start_q;
  assign scan_o.spr_start   = spr_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_scan_gen : small-raster and CLK_DIV=1 scan generator bench     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_vga_scan_gen;

  // Small raster for unit A: 24 x 13 total, /4 divider, frame = 1248 clks.
  localparam int A_D = 4;
  localparam int A_RH = 16, A_HFP = 2, A_HSW = 3, A_HBP = 3;
  localparam int A_RV = 8,  A_VFP = 1, A_VSW = 2, A_VBP = 2;
  // Unit B: default 640x480 timing with no divider.
  localparam int B_D = 1;
  localparam int B_RH = 640, B_HFP = 16, B_HSW = 96, B_HBP = 48;
  localparam int B_RV = 480, B_VFP = 10, B_VSW = 2,  B_VBP = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_scan_gen_if ifa ();
  vga_scan_gen_if ifb ();

  vga_scan_gen #(
    .CLK_DIV(A_D), .RES_H(A_RH), .H_FP(A_HFP), .H_SW(A_HSW), .H_BP(A_HBP),
    .RES_V(A_RV), .V_FP(A_VFP), .V_SW(A_VSW), .V_BP(A_VBP), .SYNC_POL(1'b0)
  ) u_a (.clk(clk), .rst(rst), .scan_o(ifa));

  vga_scan_gen #(
    .CLK_DIV(B_D), .RES_H(B_RH), .H_FP(B_HFP), .H_SW(B_HSW), .H_BP(B_HBP),
    .RES_V(B_RV), .V_FP(B_VFP), .V_SW(B_VSW), .V_BP(B_VBP), .SYNC_POL(1'b0)
  ) u_b (.clk(clk), .rst(rst), .scan_o(ifb));

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic tick; int x; int y; logic hs; logic vs; logic von; logic fs; logic ss;
  } exp_t;

  // Position is simply (edges since reset / divider) folded onto the raster.
  function automatic exp_t model(longint n, int d, int rh, int hfp, int hsw, int hbp,
                                 int rv, int vfp, int vsw, int vbp);
    exp_t e;
    int ht = rh + hfp + hsw + hbp;
    int vt = rv + vfp + vsw + vbp;
    longint pos = (n / d) % (ht * vt);
    e.tick = ((n % d) == d - 1);
    e.x    = int'(pos % ht);
    e.y    = int'(pos / ht);
    e.hs   = !((e.x >= rh + hfp) && (e.x < rh + hfp + hsw));
    e.vs   = !((e.y >= rv + vfp) && (e.y < rv + vfp + vsw));
    e.von  = (e.x < rh) && (e.y < rv);
    e.fs   = (n > 0) && ((n % d) == 0) && (pos == 0);
    e.ss   = 1'b0;
    return e;
  endfunction

  longint na = 0, nb = 0;
  bit     fired_a = 0, fired_b = 0;
  bit     valid = 0;
  exp_t   ea, eb;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      na = 0; nb = 0; fired_a = 0; fired_b = 0; valid = 1;
    end else begin
      na++; nb++;
    end
    ea = model(na, A_D, A_RH, A_HFP, A_HSW, A_HBP, A_RV, A_VFP, A_VSW, A_VBP);
    eb = model(nb, B_D, B_RH, B_HFP, B_HSW, B_HBP, B_RV, B_VFP, B_VSW, B_VBP);
    if (ea.fs) fired_a = 0;
    if (eb.fs) fired_b = 0;
    ea.ss = !rst && ((na % A_D) == 0) && (na > 0) && (ea.x == 0) &&
            (ea.y == int'(ifa.spr_y)) && (int'(ifa.spr_y) < A_RV) && !fired_a;
    eb.ss = !rst && (nb > 0) && (eb.x == 0) &&
            (eb.y == int'(ifb.spr_y)) && (int'(ifb.spr_y) < B_RV) && !fired_b;
    if (ea.ss) fired_a = 1;
    if (eb.ss) fired_b = 1;
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("a_tick", ifa.pixel_tick, ea.tick);
      chk("a_x", ifa.pixel_x, ea.x);
      chk("a_y", ifa.pixel_y, ea.y);
      chk("a_hsync", ifa.hsync, ea.hs);
      chk("a_vsync", ifa.vsync, ea.vs);
      chk("a_video_on", ifa.video_on, ea.von);
      chk("a_frame_start", ifa.frame_start, ea.fs);
      chk("a_spr_start", ifa.spr_start, ea.ss);
      chk("b_tick", ifb.pixel_tick, eb.tick);
      chk("b_x", ifb.pixel_x, eb.x);
      chk("b_y", ifb.pixel_y, eb.y);
      chk("b_hsync", ifb.hsync, eb.hs);
      chk("b_vsync", ifb.vsync, eb.vs);
      chk("b_video_on", ifb.video_on, eb.von);
      chk("b_frame_start", ifb.frame_start, eb.fs);
      chk("b_spr_start", ifb.spr_start, eb.ss);
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int k, cnt, sx, sy;
    longint c0;
    ifa.spr_y = 10'd5;
    ifb.spr_y = 10'd1023;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_px", ifa.pixel_x, 0);
    chk("rst_py", ifa.pixel_y, 0);
    chk("rst_hsync", ifa.hsync, 1);
    chk("rst_vsync", ifa.vsync, 1);
    chk("rst_video_on", ifa.video_on, 1);
    chk("rst_tick", ifa.pixel_tick, 0);
    chk("rst_frame_start", ifa.frame_start, 0);
    chk("rst_b_tick", ifb.pixel_tick, 1);

    rst = 1'b0;
    c0 = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.pixel_tick && k < 20);
    chk("first_tick_latency", k, 3);
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.pixel_tick && k < 20);
    chk("tick_period", k, 4);

    k = 0;
    while (ifa.pixel_x != 10'd16 && k < 200) begin @(negedge clk); k++; end
    chk("video_off_at_16", ifa.video_on, 0);
    k = 0;
    while (ifa.pixel_x != 10'd18 && k < 200) begin @(negedge clk); k++; end
    chk("hsync_low_at_18", ifa.hsync, 0);
    cnt = 0;
    while (!ifa.hsync && cnt < 200) begin @(negedge clk); cnt++; end
    chk("hsync_width", cnt, 12);

    k = 0;
    while (ifa.pixel_x != 10'd0 && k < 200) begin @(negedge clk); k++; end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (ifa.pixel_x == 10'd0 && cnt < 400);
    while (ifa.pixel_x != 10'd0 && cnt < 400) begin @(negedge clk); cnt++; end
    chk("line_period", cnt, 96);

    k = 0;
    while (!ifa.frame_start && k < 3000) begin @(negedge clk); k++; end
    chk("first_frame_start", cyc - c0, 1248);

    k = 0;
    while (ifa.pixel_y != 10'd9 && k < 3000) begin @(negedge clk); k++; end
    chk("vsync_low_at_9", ifa.vsync, 0);
    cnt = 0;
    while (!ifa.vsync && cnt < 3000) begin @(negedge clk); cnt++; end
    chk("vsync_width", cnt, 192);

    // Frame period with spr_y moved after its pulse: still one pulse.
    k = 0;
    while (!ifa.frame_start && k < 3000) begin @(negedge clk); k++; end
    c0 = cyc; cnt = 0; sx = -1; sy = -1;
    do begin
      @(negedge clk);
      if (ifa.spr_start) begin
        cnt++; sx = int'(ifa.pixel_x); sy = int'(ifa.pixel_y);
        ifa.spr_y = 10'd7;
      end
    end while (!ifa.frame_start && cyc - c0 < 3000);
    chk("frame_period", cyc - c0, 1248);
    chk("spr_count_y5", cnt, 1);
    chk("spr_pos_x", sx, 0);
    chk("spr_pos_y", sy, 5);

    ifa.spr_y = 10'd0;
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.frame_start && k < 3000);
    chk("spr_y0_with_frame_start", ifa.spr_start, 1);

    ifa.spr_y = 10'd10;
    cnt = 0; k = 0;
    do begin
      @(negedge clk); k++;
      if (ifa.spr_start) cnt++;
    end while (!ifa.frame_start && k < 3000);
    chk("spr_y10_none", cnt, 0);

    ifa.spr_y = 10'd5;
    k = 0;
    while (!(ifa.pixel_x == 10'd8 && ifa.pixel_y == 10'd4) && k < 3000) begin
      @(negedge clk); k++;
    end
    chk("reach_8_4", k < 3000, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_px", ifa.pixel_x, 0);
    chk("mid_rst_py", ifa.pixel_y, 0);
    chk("mid_rst_hsync", ifa.hsync, 1);
    chk("mid_rst_vsync", ifa.vsync, 1);
    chk("mid_rst_frame_start", ifa.frame_start, 0);
    rst = 1'b0;
    c0 = cyc;
    k = 0;
    while (!ifa.frame_start && k < 3000) begin @(negedge clk); k++; end
    chk("post_rst_frame_start", cyc - c0, 1248);

    k = 0;
    while (ifb.pixel_x != 10'd0 && k < 2000) begin @(negedge clk); k++; end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (ifb.pixel_x == 10'd0 && cnt < 2000);
    while (ifb.pixel_x != 10'd0 && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("b_line_period", cnt, 800);
    k = 0;
    while (ifb.pixel_x != 10'd656 && k < 2000) begin @(negedge clk); k++; end
    chk("b_hsync_low_at_656", ifb.hsync, 0);
    cnt = 0;
    while (!ifb.hsync && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("b_hsync_width", cnt, 96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
